// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants shared by the ALU and its testbench.
package alu_pkg;
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
endpackage

// File: rtl/alu_if.sv
// alu_if: operand/opcode bundle into the ALU and its registered result/flags.
//   master drives data_operandA/B, ctrl_ALUopcode, ctrl_shiftamt and reads results;
//   slave (the ALU) does the reverse.
interface alu_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    modport master (
        output data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        input  data_result, isNotEqual, isLessThan, overflow
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        output data_result, isNotEqual, isLessThan, overflow
    );
endinterface

// File: rtl/alu_cla_adder_32.sv
// cla_adder_32: 32-bit two-level carry-lookahead adder with signed-overflow output.
//   a_i, b_i : addends      cin_i : carry in
//   sum_o    : a_i+b_i+cin_i mod 2^32
//   ovf_o    : signed overflow (carry into MSB xor carry out of MSB)
module cla_adder_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        ovf_o
);
    logic [31:0] g, p;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;
    logic [32:0] c;
    // 4-bit lookahead groups; group carries chained through group generate/propagate
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        gc[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+3 -: 2] & g[4*k+1])
                  | (&p[4*k+3 -: 3] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k+1 -: 2] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+2 -: 2] & g[4*k])
                     | (&p[4*k+2 -: 3] & gc[k]);
        end
        c[32] = gc[8];
    end
    assign sum_o = p ^ c[31:0];
    assign ovf_o = c[31] ^ c[32];
endmodule

// File: rtl/alu.sv
// alu: single-cycle-latency 32-bit ALU (ADD/SUB/AND/OR/SLL/SRA) with registered
//   result and flags.
//   clock   : rising-edge clock      reset_n : async active-low reset
//   bus     : alu_if.slave -- operands, opcode, shift amount in; result and
//             isNotEqual/isLessThan/overflow out, all registered
module alu (
    input logic  clock,
    input logic  reset_n,
    alu_if.slave bus
);
    import alu_pkg::*;
    logic [31:0] a, b, add_sum, sub_diff, sll, sra, result_d, result_q;
    logic [31:0] l1, l2, l3, l4, r1, r2, r3, r4;
    logic [4:0]  op, sh;
    logic        add_ovf, sub_ovf, ne_d, lt_d, ovf_d, ne_q, lt_q, ovf_q;
    assign a  = bus.data_operandA;
    assign b  = bus.data_operandB;
    assign op = bus.ctrl_ALUopcode;
    assign sh = bus.ctrl_shiftamt;
    // Separate adder instances so the compare flags always see A-B, whatever op is.
    cla_adder_32 u_add (.a_i(a), .b_i(b),  .cin_i(1'b0), .sum_o(add_sum),  .ovf_o(add_ovf));
    cla_adder_32 u_sub (.a_i(a), .b_i(~b), .cin_i(1'b1), .sum_o(sub_diff), .ovf_o(sub_ovf));
    // Logarithmic barrel shifters: stage n shifts by 2^n when sh[n] is set.
    always_comb begin
        l1  = sh[0] ? {a[30:0], 1'b0} : a;
        l2  = sh[1] ? {l1[29:0], 2'b0} : l1;
        l3  = sh[2] ? {l2[27:0], 4'b0} : l2;
        l4  = sh[3] ? {l3[23:0], 8'b0} : l3;
        sll = sh[4] ? {l4[15:0], 16'b0} : l4;
        r1  = sh[0] ? {a[31], a[31:1]} : a;
        r2  = sh[1] ? {{2{r1[31]}}, r1[31:2]} : r1;
        r3  = sh[2] ? {{4{r2[31]}}, r2[31:4]} : r2;
        r4  = sh[3] ? {{8{r3[31]}}, r3[31:8]} : r3;
        sra = sh[4] ? {{16{r4[31]}}, r4[31:16]} : r4;
    end
    always_comb begin
        result_d = op == OP_ADD ? add_sum :
                   op == OP_SUB ? sub_diff :
                   op == OP_AND ? (a & b) :
                   op == OP_OR  ? (a | b) :
                   op == OP_SLL ? sll :
                   op == OP_SRA ? sra : '0;
        ovf_d = op == OP_ADD ? add_ovf : op == OP_SUB ? sub_ovf : 1'b0;
        ne_d  = |sub_diff;
        // Sign of the difference corrected by overflow gives true signed A<B.
        lt_d  = sub_diff[31] ^ sub_ovf;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.data_result = result_q;
    assign bus.isNotEqual  = ne_q;
    assign bus.isLessThan  = lt_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard testbench for alu with directed vectors.
module tb_alu;
    import alu_pkg::*;
    typedef struct {
        string       name;
        logic [34:0] exp;
    } exp_t;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   total = 0;
    int   passed = 0;
    exp_t sb[$];
    alu_if bus ();
    alu u_dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    always #5 clock = ~clock;
    function automatic logic [34:0] outs();
        return {bus.data_result, bus.isNotEqual, bus.isLessThan, bus.overflow};
    endfunction
    function automatic void check(string nm, logic [34:0] got, logic [34:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got res=%h ne=%b lt=%b ovf=%b, expected res=%h ne=%b lt=%b ovf=%b",
                      nm, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    endfunction
    task automatic drive(input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_ALUopcode = op;
        bus.ctrl_shiftamt  = sh;
        bus.data_operandA  = a;
        bus.data_operandB  = b;
    endtask
    task automatic issue(input string nm, input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ne, input logic lt, input logic ovf);
        exp_t e;
        @(negedge clock);
        drive(op, sh, a, b);
        e.name = nm;
        e.exp  = {res, ne, lt, ovf};
        sb.push_back(e);
    endtask
    // Monitor: one scoreboard entry is due each edge that follows an issue.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (reset_n && sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, outs(), e.exp);
        end
    end
    initial begin
        exp_t e;
        drive(OP_ADD, 5'd0, 32'd3, 32'd4);
        #1 reset_n = 1'b0;
        #1 check("reset_async", outs(), 35'd0);
        repeat (3) @(posedge clock);
        #1 check("reset_hold", outs(), 35'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(OP_ADD, 5'd0, 32'h7FFFFFFF, 32'd1);
        e.name = "add_ovf";
        e.exp  = {32'h80000000, 1'b1, 1'b0, 1'b1};
        sb.push_back(e);
        issue("sub_5_9",    OP_SUB, 5'd0,  32'd5,        32'd9,        32'hFFFFFFFC, 1, 1, 0);
        issue("sub_min_1",  OP_SUB, 5'd0,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1, 1, 1);
        issue("sub_eq",     OP_SUB, 5'd0,  32'hFFFFFFF9, 32'hFFFFFFF9, 32'h0,        0, 0, 0);
        issue("sra_4",      OP_SRA, 5'd4,  32'hF0000000, 32'd0,        32'hFF000000, 1, 1, 0);
        issue("sll_31",     OP_SLL, 5'd31, 32'd1,        32'd0,        32'h80000000, 1, 0, 0);
        issue("and",        OP_AND, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1, 1, 0);
        issue("or",         OP_OR,  5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1, 1, 0);
        issue("op_00111",   5'b00111, 5'd0, 32'd5,       32'd3,        32'h0,        1, 0, 0);
        issue("sll_0",      OP_SLL, 5'd0,  32'h12345678, 32'd9,        32'h12345678, 1, 0, 0);
        issue("sra_0",      OP_SRA, 5'd0,  32'h80000001, 32'h80000001, 32'h80000001, 0, 0, 0);
        issue("add_min2",   OP_ADD, 5'd0,  32'h80000000, 32'h80000000, 32'h0,        0, 0, 1);
        issue("sra_31",     OP_SRA, 5'd31, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1, 1, 0);
        issue("sub_max_m1", OP_SUB, 5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, 0, 1);
        issue("op_11111",   5'b11111, 5'd0, 32'h7FFFFFFF, 32'd1,       32'h0,        1, 0, 0);
        issue("add_3_4",    OP_ADD, 5'd0,  32'd3,        32'd4,        32'd7,        1, 1, 0);
        @(negedge clock);
        drive(OP_SUB, 5'd0, 32'd5, 32'd9);
        #2 reset_n = 1'b0;
        #1 check("reset_pulse", outs(), 35'd0);
        #1 reset_n = 1'b1;
        e.name = "after_pulse";
        e.exp  = {32'hFFFFFFFC, 1'b1, 1'b1, 1'b0};
        sb.push_back(e);
        issue("sll_5",      OP_SLL, 5'd5,  32'h0000000F, 32'd1,        32'h000001E0, 1, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
